// File: rtl/rcvbuf.sv
// rcvbuf: 8N1 serial receiver with a one-byte holding register and sticky overrun/framing flags
module rcvbuf #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       read,
    output logic       ready,
    output logic [7:0] data_out,
    output logic       overrun,
    output logic       frame_err,
    input  logic       serial_in
);
    localparam logic [15:0] LP_FULL = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] LP_HALF = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_sync1, r_sync2;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [2:0]  r_idx, w_idx_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic        r_ready, r_ovr, r_ferr;
    logic [7:0]  r_data;
    logic        w_rx, w_deliver, w_ferr_set, w_accept;

    assign w_rx      = r_sync2;
    assign w_accept  = w_deliver && (!r_ready || read);
    assign ready     = r_ready;
    assign data_out  = r_data;
    assign overrun   = r_ovr;
    assign frame_err = r_ferr;

    // two-flop synchronizer; idles high so a low line at release looks like a fresh start edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= serial_in;
            r_sync2 <= r_sync1;
        end
    end

    // receiver state, baud counter, bit index and shift register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // next-state logic; the counter restarts from zero on every state change
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 16'd1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_deliver   = 1'b0;
        w_ferr_set  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rx) w_state_nxt = START;
            end
            START: if (r_cnt == LP_HALF) begin
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_state_nxt = w_rx ? IDLE : DATA;
            end
            DATA: if (r_cnt == LP_FULL) begin
                w_cnt_nxt   = '0;
                w_shift_nxt = {w_rx, r_shift[7:1]};
                w_idx_nxt   = r_idx + 3'd1;
                if (r_idx == 3'd7) w_state_nxt = STOP;
            end
            STOP: if (r_cnt == LP_FULL) begin
                w_cnt_nxt   = '0;
                w_deliver   = w_rx;
                w_ferr_set  = !w_rx;
                w_state_nxt = w_rx ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                w_cnt_nxt = '0;
                if (w_rx) w_state_nxt = IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // holding register and sticky flags; a read in the delivery cycle frees the slot for the new byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ready <= 1'b0;
            r_data  <= '0;
            r_ovr   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data  <= r_shift;
                r_ready <= 1'b1;
            end else if (read) begin
                r_ready <= 1'b0;
            end
            r_ovr  <= (w_deliver && !w_accept) ? 1'b1 : read ? 1'b0 : r_ovr;
            r_ferr <= w_ferr_set ? 1'b1 : read ? 1'b0 : r_ferr;
        end
    end
endmodule

// File: tb/tb_rcvbuf.sv
// tb_rcvbuf: directed scoreboard bench for the rcvbuf serial receiver
module tb_rcvbuf;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       read = 1'b0;
    logic       serial_in = 1'b1;
    logic       ready, overrun, frame_err;
    logic [7:0] data_out;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] m_data = 8'h00;
    logic       m_ready = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;

    rcvbuf #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .read(read), .ready(ready), .data_out(data_out),
        .overrun(overrun), .frame_err(frame_err), .serial_in(serial_in)
    );

    // free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        if (exp_q.size() > 0) m_data = exp_q.pop_front();
        chk({tag, ".ready"}, {7'd0, ready}, {7'd0, m_ready});
        chk({tag, ".data"}, data_out, m_data);
        chk({tag, ".overrun"}, {7'd0, overrun}, {7'd0, m_ovr});
        chk({tag, ".frame_err"}, {7'd0, frame_err}, {7'd0, m_ferr});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_read(input string tag);
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        m_ready = 1'b0;
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        check_all(tag);
    endtask

    task automatic frame(input logic [7:0] b, input logic stop, input int rd_at, input int rst_at);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int c = 0; c < 10 * CPB; c++) begin
            serial_in = bits[c / CPB];
            read = (c == rd_at);
            if (c == rst_at) begin
                reset = 1'b0;
                #1;
                chk("rst.ready", {7'd0, ready}, 8'h00);
                chk("rst.data", data_out, 8'h00);
                chk("rst.overrun", {7'd0, overrun}, 8'h00);
                chk("rst.frame_err", {7'd0, frame_err}, 8'h00);
            end
            if (rst_at >= 0 && c == rst_at + 4) reset = 1'b1;
            @(negedge clk);
        end
        read = 1'b0;
        if (rst_at >= 0) begin
            m_ready = 1'b0;
            m_ovr = 1'b0;
            m_ferr = 1'b0;
            m_data = 8'h00;
            exp_q.delete();
        end else if (!stop) begin
            m_ferr = 1'b1;
        end else begin
            if (rd_at == 154) begin
                m_ovr = 1'b0;
                m_ferr = 1'b0;
            end
            if (!m_ready || rd_at == 154) begin
                exp_q.push_back(b);
                m_ready = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end
    endtask

    initial begin
        idle(3);
        check_all("reset");
        reset = 1'b1;
        idle(4);
        check_all("post_reset");

        frame(8'hA5, 1'b1, -1, -1);
        check_all("a5");
        do_read("a5_read");

        idle(4);
        frame(8'h3C, 1'b1, -1, -1);
        frame(8'hC3, 1'b1, -1, -1);
        check_all("overrun");
        do_read("overrun_read");

        frame(8'h55, 1'b0, -1, -1);
        check_all("ferr");
        idle(40 * CPB);
        check_all("ferr_break");
        serial_in = 1'b1;
        idle(20);
        frame(8'h0F, 1'b1, -1, -1);
        check_all("after_break");
        do_read("after_break_read");

        serial_in = 1'b0;
        idle(5);
        serial_in = 1'b1;
        idle(30);
        check_all("glitch");
        frame(8'hFF, 1'b1, -1, -1);
        check_all("ff");
        do_read("ff_read");

        frame(8'h18, 1'b1, -1, -1);
        check_all("held18");
        frame(8'h81, 1'b1, 154, -1);
        check_all("read_on_deliver");
        do_read("r81_read");

        frame(8'h77, 1'b1, -1, -1);
        frame(8'h99, 1'b1, -1, -1);
        check_all("pre_reset");
        frame(8'hF0, 1'b1, -1, 88);
        idle(10);
        check_all("after_midreset");
        frame(8'h42, 1'b1, -1, -1);
        check_all("r42");
        do_read("r42_read");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rcvbuf.md
RCVBUF -- requirements
Module: rcvbuf

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range 4..65535.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted); assertion takes effect immediately, release synchronous to clk.
REQ-004 read  input  1  consumer strobe; acknowledges and consumes the held byte.
REQ-005 ready  output  1  high = data_out holds a valid unread byte.
REQ-006 data_out  output  8  last received byte; stable while ready=1.
REQ-007 overrun  output  1  sticky: a complete byte was lost because the holding register was full.
REQ-008 frame_err  output  1  sticky: a byte was discarded because its stop bit sampled 0.
REQ-009 serial_in  input  1  asynchronous serial line, 8N1, LSB first, idle high.

Function
REQ-010 serial_in SHALL pass through a 2-flop synchronizer; all receiver decisions use the synchronized value (2-cycle input latency).
REQ-011 Receiver FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-012 IDLE: synchronized line = 0 -> START, baud counter cleared.
REQ-013 START: after CLKS_PER_BIT/2 cycles (integer divide), sample; 0 -> DATA with counter cleared and bit index 0; 1 -> IDLE (glitch rejected, no flag).
REQ-014 DATA: every CLKS_PER_BIT cycles sample one bit into shift register, LSB first; after bit index 7 -> STOP.
REQ-015 STOP: after CLKS_PER_BIT cycles sample; 1 -> deliver byte (REQ-017), go IDLE; 0 -> discard byte, set frame_err, go WAIT_HIGH.
REQ-016 WAIT_HIGH: stay until synchronized line = 1, then IDLE; no start detection while in this state (break tolerance).
REQ-017 Delivery: if ready=0, or read=1 in the same cycle, load data_out and set ready=1 on the next edge; else keep old data_out, keep ready=1, set overrun.
REQ-018 read=1 with ready=1 and no simultaneous delivery: ready=0 on the next edge; data_out unchanged.
REQ-019 read=1 with ready=0: no effect on ready/data_out.
REQ-020 Any cycle with read=1 SHALL clear overrun and frame_err on the next edge, unless the same cycle sets them (set wins).
REQ-021 Baud counter width 16 bits; counter never wraps within a state; it is cleared on every state entry.
REQ-022 ready rises exactly one clock after the stop-bit sample edge.
REQ-023 read and reception are independent: a read never stalls or resets the receiver FSM.

Reset
REQ-024 While reset=0: FSM = IDLE, ready=0, data_out=8'h00, overrun=0, frame_err=0, bit index=0, baud counter=0, shift register=0, both synchronizer flops=1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; after release, reception restarts only on a fresh falling edge (a line held low at release is treated as a start bit).

Verification (CLKS_PER_BIT=16)
REQ-026 Send 8'hA5 (bits 1,0,1,0,0,1,0,1 LSB first) with valid stop -> ready=1, data_out=8'hA5, overrun=0, frame_err=0; pulse read -> ready=0 next cycle.
REQ-027 Send 8'h3C then 8'hC3 without read -> data_out=8'h3C, ready=1, overrun=1; read -> ready=0, overrun=0.
REQ-028 Send 8'h55 with stop bit 0, line held low 40 bit times, then high -> ready=0, frame_err=1, no byte until line high and next valid frame; next frame 8'h0F delivers 8'h0F.
REQ-029 Low pulse of 5 cycles on idle line -> no START acceptance, ready=0, no flags; following frame 8'hFF received correctly.
REQ-030 Pulse read in the exact cycle a new byte 8'h81 delivers while 8'h18 held -> data_out=8'h81, ready stays 1, overrun=0.
REQ-031 Assert reset during DATA bit 4 of 8'hF0 -> all outputs at reset values; after release with line high, frame 8'h42 received as 8'h42.
